// File: rtl/pic_gpio_bank.sv
// pic_gpio_bank: PIC-style GPIO ports with output latch, TRIS, input synchroniser and interrupt-on-change
module pic_gpio_bank #(
    parameter int NUM_PORTS   = 3,
    parameter int PORT_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int SEL_W       = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [SEL_W-1:0]                port_sel,
    input  logic                            wr_lat,
    input  logic                            wr_tris,
    input  logic                            wr_ioc_mask,
    input  logic                            clr_ioc,
    input  logic [PORT_WIDTH-1:0]           wr_data,
    output logic [PORT_WIDTH-1:0]           rd_data,
    output logic [PORT_WIDTH-1:0]           rd_flags,
    input  logic [NUM_PORTS*PORT_WIDTH-1:0] pad_in,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] pad_out,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] pad_oe,
    output logic                            irq
);
    localparam int PRIME_MAX = SYNC_STAGES + 1;
    localparam int CW = $clog2(PRIME_MAX + 1);

    logic [CW-1:0] primeCnt;
    logic primed;
    logic [NUM_PORTS-1:0][PORT_WIDTH-1:0] syncOut, flags;

    // Change detection stays blind until the synchroniser and prev register hold real pin data
    assign primed = primeCnt == CW'(PRIME_MAX);

    always_ff @(posedge clk)
        primeCnt <= rst ? '0 : (primed ? primeCnt : primeCnt + 1'b1);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic hit;
        logic [PORT_WIDTH-1:0] lat, tris, mask, prev, flagReg, setF, clrF;
        logic [SYNC_STAGES-1:0][PORT_WIDTH-1:0] syncReg;
        assign hit = port_sel == SEL_W'(p);
        assign setF = (syncOut[p] ^ prev) & mask & tris & {PORT_WIDTH{primed}};
        assign clrF = (hit & clr_ioc) ? wr_data : '0;
        always_ff @(posedge clk) begin
            if (rst) begin
                lat     <= '0;
                tris    <= '1;
                mask    <= '0;
                prev    <= '0;
                flagReg <= '0;
                syncReg <= '0;
            end else begin
                if (hit & wr_lat) lat <= wr_data;
                if (hit & wr_tris) tris <= wr_data;
                if (hit & wr_ioc_mask) mask <= wr_data;
                syncReg <= {syncReg[SYNC_STAGES-2:0], pad_in[p*PORT_WIDTH +: PORT_WIDTH]};
                prev    <= syncOut[p];
                flagReg <= (flagReg & ~clrF) | setF;
            end
        end
        assign syncOut[p] = syncReg[SYNC_STAGES-1];
        assign flags[p]   = flagReg;
        assign pad_out[p*PORT_WIDTH +: PORT_WIDTH] = lat;
        assign pad_oe[p*PORT_WIDTH +: PORT_WIDTH]  = ~tris;
    end

    always_comb begin
        rd_data  = '0;
        rd_flags = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            rd_data  = (port_sel == SEL_W'(i)) ? syncOut[i] : rd_data;
            rd_flags = (port_sel == SEL_W'(i)) ? flags[i] : rd_flags;
        end
    end

    assign irq = |flags;
endmodule

// File: tb/tb_pic_gpio_bank.sv
// tb_pic_gpio_bank: directed vector table plus hand sequences for reset and IOC corner cases
module tb_pic_gpio_bank;
    logic clk = 0, rst = 0, wrLat = 0, wrTris = 0, wrMask = 0, clrIoc = 0;
    logic [1:0] sel = 0;
    logic [7:0] wrData = 0, rdData, rdFlags;
    logic [23:0] padIn = 0, padOut, padOe;
    logic irq;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    pic_gpio_bank dut (
        .clk(clk), .rst(rst), .port_sel(sel), .wr_lat(wrLat), .wr_tris(wrTris),
        .wr_ioc_mask(wrMask), .clr_ioc(clrIoc), .wr_data(wrData), .rd_data(rdData),
        .rd_flags(rdFlags), .pad_in(padIn), .pad_out(padOut), .pad_oe(padOe), .irq(irq)
    );

    typedef struct {
        logic r; logic [1:0] s; logic wl, wt, wm, cl; logic [7:0] d; logic [23:0] pin;
        logic [7:0] eRd, eFl; logic eIrq; logic [23:0] ePo, eOe;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [1:0] s, logic wl, logic wt, logic wm, logic cl,
                                logic [7:0] d, logic [23:0] pin, logic [7:0] eRd, logic [7:0] eFl,
                                logic eIrq, logic [23:0] ePo, logic [23:0] eOe);
        vec_t v;
        v.r = r; v.s = s; v.wl = wl; v.wt = wt; v.wm = wm; v.cl = cl; v.d = d; v.pin = pin;
        v.eRd = eRd; v.eFl = eFl; v.eIrq = eIrq; v.ePo = ePo; v.eOe = eOe;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic r, input logic [1:0] s, input logic wl, input logic wt,
                       input logic wm, input logic cl, input logic [7:0] d, input logic [23:0] pin);
        rst = r; sel = s; wrLat = wl; wrTris = wt; wrMask = wm; clrIoc = cl; wrData = d; padIn = pin;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // r  s  wl wt wm cl  d      pin          rd     fl     irq po          oe
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 24'h000000, 8'h00, 8'h00, 0, 24'h000000, 24'h000000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 24'h000000, 8'h00, 8'h00, 0, 24'h000000, 24'h000000));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 24'h000000, 8'h00, 8'h00, 0, 24'h000000, 24'h000000));
        tbl.push_back(mk(0, 2, 0, 0, 0, 0, 8'h00, 24'h000000, 8'h00, 8'h00, 0, 24'h000000, 24'h000000));
        tbl.push_back(mk(0, 3, 0, 0, 0, 0, 8'h00, 24'h000000, 8'h00, 8'h00, 0, 24'h000000, 24'h000000));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 8'h0F, 24'h000000, 8'h00, 8'h00, 0, 24'h000000, 24'h00F000));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 8'hA5, 24'h000000, 8'h00, 8'h00, 0, 24'h00A500, 24'h00F000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 24'h000000, 8'h00, 8'h00, 0, 24'h00A500, 24'h00F000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 24'h00003C, 8'h00, 8'h00, 0, 24'h00A500, 24'h00F000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 24'h00003C, 8'h3C, 8'h00, 0, 24'h00A500, 24'h00F000));
        tbl.push_back(mk(0, 2, 0, 0, 1, 0, 8'h01, 24'h00003C, 8'h00, 8'h00, 0, 24'h00A500, 24'h00F000));
        tbl.push_back(mk(0, 2, 0, 0, 0, 0, 8'h00, 24'h01003C, 8'h00, 8'h00, 0, 24'h00A500, 24'h00F000));
        tbl.push_back(mk(0, 2, 0, 0, 0, 0, 8'h00, 24'h01003C, 8'h01, 8'h00, 0, 24'h00A500, 24'h00F000));
        tbl.push_back(mk(0, 2, 0, 0, 0, 0, 8'h00, 24'h01003C, 8'h01, 8'h01, 1, 24'h00A500, 24'h00F000));
        tbl.push_back(mk(0, 2, 0, 0, 0, 1, 8'h01, 24'h01003C, 8'h01, 8'h00, 0, 24'h00A500, 24'h00F000));
        tbl.push_back(mk(0, 2, 0, 0, 0, 0, 8'h00, 24'h00003C, 8'h01, 8'h00, 0, 24'h00A500, 24'h00F000));
        tbl.push_back(mk(0, 2, 0, 0, 0, 0, 8'h00, 24'h00003C, 8'h00, 8'h00, 0, 24'h00A500, 24'h00F000));
        tbl.push_back(mk(0, 2, 0, 0, 0, 1, 8'h01, 24'h00003C, 8'h00, 8'h01, 1, 24'h00A500, 24'h00F000));
        tbl.push_back(mk(0, 2, 0, 0, 0, 1, 8'h01, 24'h00003C, 8'h00, 8'h00, 0, 24'h00A500, 24'h00F000));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 8'hF0, 24'h00003C, 8'h00, 8'h00, 0, 24'h00A500, 24'h00F000));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 24'h00F03C, 8'h00, 8'h00, 0, 24'h00A500, 24'h00F000));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 24'h00F03C, 8'hF0, 8'h00, 0, 24'h00A500, 24'h00F000));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 24'h00F03C, 8'hF0, 8'h00, 0, 24'h00A500, 24'h00F000));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 24'h00F03C, 8'hF0, 8'h00, 0, 24'h00A500, 24'h00F000));
        tbl.push_back(mk(0, 3, 1, 1, 1, 0, 8'hFF, 24'h00F03C, 8'h00, 8'h00, 0, 24'h00A500, 24'h00F000));

        for (int i = 0; i < tbl.size(); i++) begin
            drv(tbl[i].r, tbl[i].s, tbl[i].wl, tbl[i].wt, tbl[i].wm, tbl[i].cl, tbl[i].d, tbl[i].pin);
            chk($sformatf("row%0d rd_data", i), 32'(rdData), 32'(tbl[i].eRd));
            chk($sformatf("row%0d rd_flags", i), 32'(rdFlags), 32'(tbl[i].eFl));
            chk($sformatf("row%0d irq", i), 32'(irq), 32'(tbl[i].eIrq));
            chk($sformatf("row%0d pad_out", i), 32'(padOut), 32'(tbl[i].ePo));
            chk($sformatf("row%0d pad_oe", i), 32'(padOe), 32'(tbl[i].eOe));
        end

        // Set a flag on port 2, then reset mid-operation while port 0 pins change
        for (int k = 0; k < 3; k++) drv(0, 2, 0, 0, 0, 0, 8'h00, 24'h01F03C);
        chk("pre-rst flag", 32'(rdFlags), 32'h01);
        chk("pre-rst irq", 32'(irq), 32'h1);
        drv(1, 0, 0, 0, 0, 0, 8'h00, 24'h01F0FF);
        chk("rst pad_out", 32'(padOut), 32'h0);
        chk("rst pad_oe", 32'(padOe), 32'h0);
        chk("rst irq", 32'(irq), 32'h0);
        chk("rst rd_data", 32'(rdData), 32'h0);
        drv(0, 0, 0, 0, 1, 0, 8'hFF, 24'h01F0FF);
        chk("rst+1 rd_data", 32'(rdData), 32'h0);
        chk("rst+1 flags", 32'(rdFlags), 32'h0);
        for (int k = 2; k <= 5; k++) begin
            drv(0, 0, 0, 0, 0, 0, 8'h00, 24'h01F0FF);
            chk($sformatf("prime rst+%0d rd_data", k), 32'(rdData), 32'hFF);
            chk($sformatf("prime rst+%0d flags", k), 32'(rdFlags), 32'h0);
            chk($sformatf("prime rst+%0d irq", k), 32'(irq), 32'h0);
        end

        // Post-reset IOC works on a masked input bit
        drv(0, 0, 0, 0, 0, 0, 8'h00, 24'h01F0FE);
        drv(0, 0, 0, 0, 0, 0, 8'h00, 24'h01F0FE);
        chk("ioc0 N+2 flags", 32'(rdFlags), 32'h0);
        drv(0, 0, 0, 0, 0, 0, 8'h00, 24'h01F0FE);
        chk("ioc0 N+3 flags", 32'(rdFlags), 32'h01);
        chk("ioc0 N+3 irq", 32'(irq), 32'h1);

        // Turning bits into outputs keeps old flags and blocks new ones
        drv(0, 0, 0, 1, 0, 0, 8'h00, 24'h01F0FE);
        chk("tris keep flags", 32'(rdFlags), 32'h01);
        chk("tris pad_oe", 32'(padOe), 32'h0000FF);
        for (int k = 0; k < 4; k++) drv(0, 0, 0, 0, 0, 0, 8'h00, 24'h01F0FC);
        chk("output bit no flag", 32'(rdFlags), 32'h01);
        chk("output bit rd_data", 32'(rdData), 32'hFC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
